// File: rtl/nv_fifo_pkg.sv
// nv_fifo_pkg
// Shared sizing for the 256x8 FIFO controller and its RAM.
//   DEPTH : number of FIFO entries (equals RAM depth)
//   AW    : RAM address width, log2(DEPTH)
//   DW    : payload width (equals RAM width)
//   CW    : occupancy counter width, AW+1 so that a full FIFO (DEPTH) is representable
//   ptr_t : RAM pointer type (wraps naturally mod DEPTH)
//   cnt_t : occupancy / unissued counter type
package nv_fifo_pkg;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int CW    = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

endpackage : nv_fifo_pkg

// File: rtl/nv_ram_rwst_256x8.sv
// nv_ram_rwst_256x8
// Two-port 256x8 RAM with a registered read address.
//   clk           : clock, all state on the rising edge
//   ra / re       : read address, captured into the address register when re=1
//   dout          : data at the captured read address
//   wa / we / di  : write address, write enable, write data
//   pwrbus_ram_pd : power-control bus, not used by this behavioural model
// While re=0 the address register holds, so dout stays stable as long as the
// addressed location is not rewritten.
module nv_ram_rwst_256x8
  import nv_fifo_pkg::*;
(
  input  logic          clk,
  input  logic [AW-1:0] ra,
  input  logic          re,
  output logic [DW-1:0] dout,
  input  logic [AW-1:0] wa,
  input  logic          we,
  input  logic [DW-1:0] di,
  input  logic [31:0]   pwrbus_ram_pd
);

  logic [DW-1:0] mem_q [0:DEPTH-1];
  logic [AW-1:0] ra_q;
  logic          unused_pd;

  assign unused_pd = ^pwrbus_ram_pd;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wa] <= di;
    end
    if (re) begin
      ra_q <= ra;
    end
  end

  assign dout = mem_q[ra_q];

endmodule : nv_ram_rwst_256x8

// File: rtl/nv_fifo_ctrl_256x8.sv
// nv_fifo_ctrl_256x8
// Synchronous FIFO controller (256 x 8b) driving an external two-port RAM.
//   nvdla_core_clk / nvdla_core_rst : clock, synchronous active-high reset
//   wr_pvld / wr_prdy / wr_pd        : producer valid/ready handshake and payload
//   rd_pvld / rd_prdy / rd_pd        : consumer valid/ready handshake and payload
//   ram_we / ram_wa / ram_di         : RAM write port (one write per push)
//   ram_re / ram_ra                  : RAM read port (one read issue per entry)
//   ram_dout                         : RAM data for the address captured at the last ram_re
//   fifo_count                       : entries written and not yet popped
//   fifo_idle                        : no entries held and no read data pending
// Two counters track the queue: occ (written, not yet popped) gates the write
// side, unissued (written, not yet sent to the RAM read port) gates issue.
module nv_fifo_ctrl_256x8
  import nv_fifo_pkg::*;
(
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rst,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_di,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  input  logic [DW-1:0] ram_dout,
  output logic [CW-1:0] fifo_count,
  output logic          fifo_idle
);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t occ_q, occ_d;
  cnt_t unissued_q, unissued_d;
  logic rd_pvld_q, rd_pvld_d;

  logic push;
  logic issue;
  logic pop;

  // Handshake decode. wr_prdy depends on registered occupancy only, so a pop
  // on a full FIFO frees the slot for the following cycle, not this one.
  // unissued is registered, so an entry pushed this cycle cannot be issued
  // until the next one: the RAM never sees re and we to the same address.
  assign wr_prdy = (occ_q != DEPTH_CNT);
  assign push    = wr_pvld && wr_prdy;
  assign pop     = rd_pvld_q && rd_prdy;
  assign issue   = (unissued_q != '0) && (!rd_pvld_q || rd_prdy);

  // State register
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      unissued_q <= '0;
      rd_pvld_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      unissued_q <= unissued_d;
      rd_pvld_q  <= rd_pvld_d;
    end
  end

  // Next-state logic
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q + cnt_t'(push) - cnt_t'(pop);
    unissued_d = unissued_q + cnt_t'(push) - cnt_t'(issue);
    rd_pvld_d  = rd_pvld_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end

    // Issue refills the output stage; a pop without issue empties it.
    if (issue) begin
      rd_pvld_d = 1'b1;
    end else if (pop) begin
      rd_pvld_d = 1'b0;
    end
  end

  // Outputs
  always_comb begin
    ram_we     = push;
    ram_wa     = wr_ptr_q;
    ram_di     = wr_pd;
    ram_re     = issue;
    ram_ra     = rd_ptr_q;
    rd_pvld    = rd_pvld_q;
    rd_pd      = ram_dout;
    fifo_count = occ_q;
    fifo_idle  = (occ_q == '0) && !rd_pvld_q;
  end

endmodule : nv_fifo_ctrl_256x8
